ff_excitation_gen: RTL and testbench
====================================

FF_EXCITATION_GEN -- requirements
Module: ff_excitation_gen

Interface
REQ-001 Parameter CNT_W, default 8, is the width of the toggle counter.
REQ-002 Parameter DC_VAL, default 0, is the value driven on every excitation-table don't-care position.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  target bit is valid.
REQ-006 in_bit  in  1  desired next flop state Q+.
REQ-007 in_ready  out  1  block accepts in_bit this cycle.
REQ-008 load  in  1  force state resync; no output is generated.
REQ-009 load_val  in  1  value loaded into the state and model registers when load=1.
REQ-010 out_valid  out  1  the excitation word is valid.
REQ-011 out_ready  in  1  downstream consumes the excitation word.
REQ-012 out_s, out_r, out_j, out_k, out_t, out_d  out  1 each  registered excitation inputs for the Q->Q+ transition.
REQ-013 out_q_prev, out_q_next  out  1 each  the transition the word describes.
REQ-014 toggle_cnt  out  CNT_W  saturating count of accepted transitions with Q != Q+.
REQ-015 err  out  1  sticky self-check mismatch flag.

Function
REQ-016 The block SHALL hold a current-state register q, which mirrors the flop being driven.
REQ-017 Accept condition: in_valid & in_ready; in_ready = ~load & (~out_valid | out_ready).
REQ-018 Excitation per transition (x=DC_VAL):
  - 0->0: S=0, R=x, J=0, K=x, T=0, D=0.
  - 0->1: S=1, R=0, J=1, K=x, T=1, D=1.
  - 1->0: S=0, R=1, J=x, K=1, T=1, D=0.
  - 1->1: S=x, R=0, J=x, K=0, T=0, D=1.
REQ-019 On accept, the excitation word, out_q_prev=q and out_q_next=in_bit SHALL be registered, out_valid SHALL be set to 1, and q SHALL be set to in_bit; latency from accept to out_valid is 1 cycle.
REQ-020 Output FSM has two states:
  - EMPTY->FULL on accept.
  - FULL->EMPTY on out_ready without accept.
  - FULL->FULL on out_ready with accept, which is a back-to-back transfer with no bubble.
REQ-021 While FULL and out_ready=0, all out_* signals SHALL hold stable and in_ready SHALL be 0.
REQ-022 load=1 SHALL set q, qm_sr and qm_t to load_val and SHALL NOT alter out_valid, the word, or toggle_cnt. load has priority over in_valid in the same cycle; that input is not accepted.
REQ-023 toggle_cnt SHALL increment by 1 on each accept with q != in_bit and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-024 Self-check models SHALL update on accept:
  - qm_sr <= S | (~R & qm_sr).
  - qm_t <= qm_t ^ T.
  - These updates use the new word's S, R and T values.
REQ-025 err SHALL be set, and remain set until rst, if qm_sr or qm_t differs from in_bit after a model update. For either DC_VAL this SHALL never occur in a correct implementation.
REQ-026 A generated word SHALL never have S=R=1.

Reset
REQ-027 On rst=1 at a clock edge, the following SHALL be cleared to 0: q, qm_sr, qm_t, out_valid, all excitation outputs, out_q_prev, out_q_next, toggle_cnt and err.
REQ-028 Reset mid-transfer SHALL drop any pending FULL word without handshake completion.
REQ-029 rst SHALL have priority over load and accept.
REQ-030 in_ready SHALL be 0 during the rst cycle.

Structure
REQ-031 Package ff_exc_pkg SHALL hold:
  - the excitation-word struct (s, r, j, k, t, d);
  - the transition-code localparams (T00, T01, T10, T11);
  - the FSM state enum (EMPTY, FULL).
REQ-032 One combinational sub-module, ff_exc_table, SHALL map (q, q_next, DC_VAL) to the excitation word. The top level contains q, the output register/FSM, the counter and the self-check models.

Verification
REQ-033 Reset, DC_VAL=0, out_ready=1, stream 1,1,0,0 -> words:
  - S/R/J/K/T/D = 1/0/1/0/1/1;
  - 0/0/0/0/0/1;
  - 0/1/0/1/1/0;
  - 0/0/0/0/0/0;
  - toggle_cnt=2, err=0.
REQ-034 DC_VAL=1, stream 0,1,1,0 -> 0->0 word R=1, K=1; 1->1 word S=1, J=1; S=R=1 never seen; err=0.
REQ-035 Backpressure test:
  - Stimulus: out_ready=0 for 5 cycles after the first accept of in_bit=1.
  - Required: word held stable; in_ready=0; second input stalls.
  - Then out_ready=1 with continuous in_valid: one word per cycle, no loss or duplication.
REQ-036 load=1, load_val=1 with in_valid=1, in_bit=0 in the same cycle -> input not accepted; next cycle accept of in_bit=0 gives out_q_prev=1, T=1, R=1.
REQ-037 CNT_W=3, alternating stream of 10 bits (all toggles) -> toggle_cnt reads 7 and stays 7.
REQ-038 rst asserted while FULL with out_ready=0 -> next cycle out_valid=0, toggle_cnt=0, q=0; a following in_bit=1 produces 0->1 excitation.

Source files
------------

// File: rtl/ff_exc_pkg.sv
// Shared types for the flip-flop excitation generator: excitation word,
// transition codes {q, q_next} and the output-register state.
package ff_exc_pkg;

   typedef struct packed {
      logic s;
      logic r;
      logic j;
      logic k;
      logic t;
      logic d;
   } exc_word_t;

   localparam logic [1:0] T00 = 2'b00;
   localparam logic [1:0] T01 = 2'b01;
   localparam logic [1:0] T10 = 2'b10;
   localparam logic [1:0] T11 = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/ff_exc_table.sv
// Combinational excitation table: maps a Q -> Q+ transition to the SR/JK/T/D
// inputs that produce it; don't-care positions are driven with DC_VAL.
module ff_exc_table
   import ff_exc_pkg::*;
#(
   parameter bit DC_VAL = 1'b0
) (
   input  logic      q_i,
   input  logic      q_next_i,
   output exc_word_t word_o
);

   always_comb begin
      word_o = '0;
      unique case ({q_i, q_next_i})
         T00: begin
            word_o.s = 1'b0;
            word_o.r = DC_VAL;
            word_o.j = 1'b0;
            word_o.k = DC_VAL;
            word_o.t = 1'b0;
            word_o.d = 1'b0;
         end
         T01: begin
            word_o.s = 1'b1;
            word_o.r = 1'b0;
            word_o.j = 1'b1;
            word_o.k = DC_VAL;
            word_o.t = 1'b1;
            word_o.d = 1'b1;
         end
         T10: begin
            word_o.s = 1'b0;
            word_o.r = 1'b1;
            word_o.j = DC_VAL;
            word_o.k = 1'b1;
            word_o.t = 1'b1;
            word_o.d = 1'b0;
         end
         T11: begin
            word_o.s = DC_VAL;
            word_o.r = 1'b0;
            word_o.j = DC_VAL;
            word_o.k = 1'b0;
            word_o.t = 1'b0;
            word_o.d = 1'b1;
         end
         default: word_o = '0;
      endcase
   end

endmodule

// File: rtl/ff_excitation_gen.sv
// Tracks the state of a driven flop and emits a registered excitation word per
// requested transition over a valid/ready stream, with SR and T self-check models.
module ff_excitation_gen
   import ff_exc_pkg::*;
#(
   parameter int unsigned CNT_W  = 8,
   parameter bit          DC_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   input  logic             in_bit_i,
   output logic             in_ready_o,
   input  logic             load_i,
   input  logic             load_val_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             out_s_o,
   output logic             out_r_o,
   output logic             out_j_o,
   output logic             out_k_o,
   output logic             out_t_o,
   output logic             out_d_o,
   output logic             out_q_prev_o,
   output logic             out_q_next_o,
   output logic [CNT_W-1:0] toggle_cnt_o,
   output logic             err_o
);

   out_state_e       state_q;
   exc_word_t        word_q;
   exc_word_t        word_d;
   logic             q_q;
   logic             qm_sr_q;
   logic             qm_sr_d;
   logic             qm_t_q;
   logic             qm_t_d;
   logic             q_prev_q;
   logic             q_next_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             accept;
   logic             toggles;
   logic             cnt_sat;

   ff_exc_table #(
      .DC_VAL (DC_VAL)
   ) u_table (
      .q_i      (q_q),
      .q_next_i (in_bit_i),
      .word_o   (word_d)
   );

   assign out_valid_o = (state_q == FULL);
   assign in_ready_o  = ~rst & ~load_i & (~out_valid_o | out_ready_i);
   assign accept      = in_valid_i & in_ready_o;

   // Models are advanced with the word being registered this cycle.
   always_comb begin
      qm_sr_d = word_d.s | (~word_d.r & qm_sr_q);
      qm_t_d  = qm_t_q ^ word_d.t;
      toggles = q_q ^ in_bit_i;
      cnt_sat = &cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         word_q   <= '0;
         q_q      <= 1'b0;
         qm_sr_q  <= 1'b0;
         qm_t_q   <= 1'b0;
         q_prev_q <= 1'b0;
         q_next_q <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            state_q <= FULL;
         end else if (out_ready_i) begin
            state_q <= EMPTY;
         end

         if (load_i) begin
            q_q     <= load_val_i;
            qm_sr_q <= load_val_i;
            qm_t_q  <= load_val_i;
         end else if (accept) begin
            q_q      <= in_bit_i;
            word_q   <= word_d;
            q_prev_q <= q_q;
            q_next_q <= in_bit_i;
            qm_sr_q  <= qm_sr_d;
            qm_t_q   <= qm_t_d;
            if (toggles && !cnt_sat) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((qm_sr_d != in_bit_i) || (qm_t_d != in_bit_i)) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign out_s_o      = word_q.s;
   assign out_r_o      = word_q.r;
   assign out_j_o      = word_q.j;
   assign out_k_o      = word_q.k;
   assign out_t_o      = word_q.t;
   assign out_d_o      = word_q.d;
   assign out_q_prev_o = q_prev_q;
   assign out_q_next_o = q_next_q;
   assign toggle_cnt_o = cnt_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_ff_excitation_gen.sv
// Bench for ff_excitation_gen: two instances (DC_VAL=0/CNT_W=8, DC_VAL=1/CNT_W=3)
// share one stimulus stream and are compared against a transition-level model.
module tb_ff_excitation_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_valid, in_bit, load, load_val, out_ready;

   logic       rdy_a, val_a, sa, ra, ja, ka, ta, da, qp_a, qn_a, err_a;
   logic [7:0] cnt_a;
   logic       rdy_b, val_b, sb, rb, jb, kb, tb, db, qp_b, qn_b, err_b;
   logic [2:0] cnt_b;

   ff_excitation_gen #(.CNT_W(8), .DC_VAL(1'b0)) dut_a (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_bit_i(in_bit), .in_ready_o(rdy_a),
      .load_i(load), .load_val_i(load_val), .out_valid_o(val_a), .out_ready_i(out_ready),
      .out_s_o(sa), .out_r_o(ra), .out_j_o(ja), .out_k_o(ka), .out_t_o(ta), .out_d_o(da),
      .out_q_prev_o(qp_a), .out_q_next_o(qn_a), .toggle_cnt_o(cnt_a), .err_o(err_a)
   );

   ff_excitation_gen #(.CNT_W(3), .DC_VAL(1'b1)) dut_b (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_bit_i(in_bit), .in_ready_o(rdy_b),
      .load_i(load), .load_val_i(load_val), .out_valid_o(val_b), .out_ready_i(out_ready),
      .out_s_o(sb), .out_r_o(rb), .out_j_o(jb), .out_k_o(kb), .out_t_o(tb), .out_d_o(db),
      .out_q_prev_o(qp_b), .out_q_next_o(qn_b), .toggle_cnt_o(cnt_b), .err_o(err_b)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: flop state, pending word and total toggles seen.
   bit         m_q, m_valid, m_prev, m_next;
   logic [5:0] m_word_a, m_word_b;
   int         m_toggles;

   // {S,R,J,K,T,D} from the characteristic behaviour of each flop type.
   function automatic logic [5:0] exc(bit qp, bit qn, bit dc);
      bit s, r, j, k, t, d;
      d = qn;
      t = qp ^ qn;
      j = qp ? dc : qn;
      k = qp ? ~qn : dc;
      s = qp ? (qn ? dc : 1'b0) : qn;
      r = qp ? ~qn : (qn ? 1'b0 : dc);
      return {s, r, j, k, t, d};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int sat_a, sat_b;
      sat_a = (m_toggles > 255) ? 255 : m_toggles;
      sat_b = (m_toggles > 7) ? 7 : m_toggles;
      chk("a_out_valid", 32'(val_a), 32'(m_valid));
      chk("b_out_valid", 32'(val_b), 32'(m_valid));
      chk("a_word", 32'({sa, ra, ja, ka, ta, da}), 32'(m_word_a));
      chk("b_word", 32'({sb, rb, jb, kb, tb, db}), 32'(m_word_b));
      chk("a_q_prev_next", 32'({qp_a, qn_a}), 32'({m_prev, m_next}));
      chk("b_q_prev_next", 32'({qp_b, qn_b}), 32'({m_prev, m_next}));
      chk("a_toggle_cnt", 32'(cnt_a), 32'(sat_a));
      chk("b_toggle_cnt", 32'(cnt_b), 32'(sat_b));
      chk("a_err", 32'(err_a), 32'd0);
      chk("b_err", 32'(err_b), 32'd0);
      chk("a_s_and_r", 32'(sa & ra), 32'd0);
      chk("b_s_and_r", 32'(sb & rb), 32'd0);
   endtask

   // One clock: drive at the negedge, check in_ready, clock, update model,
   // then check registered outputs at the following negedge.
   task automatic step(input bit r, input bit iv, input bit ib, input bit ld, input bit lv,
                       input bit ordy);
      bit exp_rdy, acc;
      rst = r; in_valid = iv; in_bit = ib; load = ld; load_val = lv; out_ready = ordy;
      #1;
      exp_rdy = !r && !ld && (!m_valid || ordy);
      chk("a_in_ready", 32'(rdy_a), 32'(exp_rdy));
      chk("b_in_ready", 32'(rdy_b), 32'(exp_rdy));
      @(posedge clk);
      if (r) begin
         m_q = 0; m_valid = 0; m_prev = 0; m_next = 0;
         m_word_a = '0; m_word_b = '0; m_toggles = 0;
      end else begin
         acc = iv && exp_rdy;
         if (ld) m_q = lv;
         if (acc) begin
            m_word_a = exc(m_q, ib, 1'b0);
            m_word_b = exc(m_q, ib, 1'b1);
            m_prev = m_q;
            m_next = ib;
            if (m_q != ib) m_toggles++;
            m_q = ib;
            m_valid = 1;
         end else if (ordy) begin
            m_valid = 0;
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      bit seq [4];
      m_q = 0; m_valid = 0; m_prev = 0; m_next = 0;
      m_word_a = '0; m_word_b = '0; m_toggles = 0;
      rst = 1; in_valid = 0; in_bit = 0; load = 0; load_val = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(1, 1, 1, 0, 0, 1);

      // Stream 1,1,0,0 with DC_VAL=0.
      step(0, 1, 1, 0, 0, 1);
      chk("r33_w0", 32'({sa, ra, ja, ka, ta, da}), 32'(6'b101011));
      step(0, 1, 1, 0, 0, 1);
      chk("r33_w1", 32'({sa, ra, ja, ka, ta, da}), 32'(6'b000001));
      step(0, 1, 0, 0, 0, 1);
      chk("r33_w2", 32'({sa, ra, ja, ka, ta, da}), 32'(6'b010110));
      step(0, 1, 0, 0, 0, 1);
      chk("r33_w3", 32'({sa, ra, ja, ka, ta, da}), 32'(6'b000000));
      chk("r33_cnt", 32'(cnt_a), 32'd2);

      // Stream 0,1,1,0 from reset with DC_VAL=1.
      step(1, 0, 0, 0, 0, 1);
      seq = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         step(0, 1, seq[i], 0, 0, 1);
         if (i == 0) chk("r34_00_rk", 32'({rb, kb}), 32'(2'b11));
         if (i == 2) chk("r34_11_sj", 32'({sb, jb}), 32'(2'b11));
      end

      // Backpressure: hold the first word for five cycles, then stream.
      step(1, 0, 0, 0, 0, 1);
      step(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1'($urandom), 0, 0, 0);
         chk("bp_held_word", 32'({sa, ra, ja, ka, ta, da, qp_a, qn_a}), 32'(8'b10101101));
      end
      for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom), 0, 0, 1);

      // Load wins over a same-cycle input.
      step(1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 1, 1, 1);
      step(0, 1, 0, 0, 0, 1);
      chk("load_prev_t_r", 32'({qp_a, ta, ra}), 32'(3'b111));

      // Ten toggles saturate the 3-bit counter at 7.
      step(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 1'((i + 1) % 2), 0, 0, 1);
      chk("sat_cnt7", 32'(cnt_b), 32'd7);
      step(0, 1, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("sat_cnt7_hold", 32'(cnt_b), 32'd7);

      // Reset while FULL and stalled.
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_full_valid", 32'(val_a), 32'd0);
      chk("rst_full_cnt", 32'(cnt_a), 32'd0);
      step(0, 1, 1, 0, 0, 1);
      chk("rst_full_next", 32'({qp_a, sa, ra, ja, ta, da}), 32'(6'b010111));

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
